pci_cfg_arb: RTL and testbench

// - Arbitrates N requesters (PCI target decode, debug/host port, ...) for the single
//   pci_cfg register port. Sequences one access at a time: drives cfg_enable for

---
 rtl/pci_cfg_arb.sv | 200 ++++++++++++++++++++
 tb/tb_pci_cfg_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_cfg_arb.sv
// -----------------------------------------------------------------------------
// pci_cfg_arb
//
// Arbitrates NREQ requesters for the single pci_cfg register port. One access is
// sequenced at a time through IDLE -> ISSUE -> WAIT -> RESP, so a transaction
// occupies exactly four cycles:
//   IDLE  : winner selected, req_ready[winner] pulses, request fields latched
//   ISSUE : cfg_enable high for this cycle only
//   WAIT  : pci_cfg's registered cfg_read_val is captured into rsp_rdata
//   RESP  : rsp_valid[owner] pulses (write acks included, with rsp_rdata = 0)
//
// Optional feature macro: PCI_CFG_ARB_RR_EN
//   defined   : round-robin; search starts one past the last winner
//   undefined : fixed priority; lowest valid index wins, no pointer exists
//
// Parameters
//   NREQ   number of requesters, 1..8
//   OFF_W  config dword offset width, matches pci_cfg cfg_offset
//
// Ports
//   clk            clock, all logic on posedge
//   rst            asynchronous active-low reset
//   req_valid      per-requester request
//   req_ready      one-hot accept pulse (combinational, IDLE only)
//   req_iswrite    per-requester direction, 1 = write
//   req_offset     packed offsets, requester i at [i*OFF_W +: OFF_W]
//   req_wdata      packed write data, requester i at [i*32 +: 32]
//   rsp_valid      one-hot completion pulse to the owning requester
//   rsp_rdata      read data, held until the next capture
//   cfg_enable     access strobe to pci_cfg
//   cfg_iswrite    access direction to pci_cfg
//   cfg_offset     access offset to pci_cfg
//   cfg_write_val  write data to pci_cfg
//   cfg_read_val   registered read data from pci_cfg, valid one cycle after enable
// -----------------------------------------------------------------------------
module pci_cfg_arb #(
  parameter int NREQ  = 2,
  parameter int OFF_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_iswrite,
  input  logic [NREQ*OFF_W-1:0] req_offset,
  input  logic [NREQ*32-1:0]    req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  cfg_enable,
  output logic                  cfg_iswrite,
  output logic [OFF_W-1:0]      cfg_offset,
  output logic [31:0]           cfg_write_val,
  input  logic [31:0]           cfg_read_val
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;

`ifdef PCI_CFG_ARB_RR_EN
  // Index of the most recent winner; the search begins just above it.
  logic [IDX_W-1:0]   ptr;
  logic [NREQ-1:0]    upper;
`endif

  logic [NREQ-1:0]    cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    owner_oh;
  logic               sel_wr;
  logic [OFF_W-1:0]   sel_off;
  logic [31:0]        sel_wdata;

  // ---------------------------------------------------------------------------
  // Winner selection and request field mux.
  // Round-robin is done as two fixed-priority passes: first over requesters with
  // an index above the pointer, then (if none) over all requesters. That gives
  // the "pointer+1 mod NREQ, first valid wins" order with constant loop indices.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    cand      = req_valid;
    win_idx   = '0;
    grant     = '0;
    owner_oh  = '0;
    sel_wr    = 1'b0;
    sel_off   = '0;
    sel_wdata = '0;

`ifdef PCI_CFG_ARB_RR_EN
    upper = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper[i] = (i > int'(ptr));
    end
    if ((req_valid & upper) != '0) begin
      cand = req_valid & upper;
    end
`endif

    win_found = (cand != '0);

    // Scan downwards so the lowest candidate index is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = IDX_W'(i);
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      grant[i]    = win_found && (win_idx == IDX_W'(i));
      owner_oh[i] = (owner == IDX_W'(i));
      if (win_idx == IDX_W'(i)) begin
        sel_wr    = req_iswrite[i];
        sel_off   = req_offset[i*OFF_W +: OFF_W];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // The accept pulse has to be visible in the same IDLE cycle the requester is
  // chosen, so it is combinational. It is also forced low while reset is held,
  // keeping every output at 0 during reset even with requests pending.
  assign req_ready = (rst && (state == IDLE)) ? grant : '0;

  // ---------------------------------------------------------------------------
  // Sequencer. The cfg_* registers double as the latched request fields: they
  // are loaded on acceptance and then simply hold, which is what pci_cfg sees
  // outside ISSUE (don't-care there since cfg_enable is low).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, including datapath holding registers, is reset so
      // all outputs read 0 immediately on reset and an aborted access leaves no
      // trace behind.
      state         <= IDLE;
      owner         <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      cfg_enable    <= 1'b0;
      cfg_iswrite   <= 1'b0;
      cfg_offset    <= '0;
      cfg_write_val <= '0;
`ifdef PCI_CFG_ARB_RR_EN
      ptr           <= IDX_W'(NREQ - 1);
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block updates from the values present before the clock edge.
      case (state)
        IDLE: begin
          if (win_found) begin
            owner         <= win_idx;
            cfg_iswrite   <= sel_wr;
            cfg_offset    <= sel_off;
            cfg_write_val <= sel_wdata;
            cfg_enable    <= 1'b1;
`ifdef PCI_CFG_ARB_RR_EN
            ptr           <= win_idx;
`endif
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          cfg_enable <= 1'b0;
          state      <= WAIT;
        end

        WAIT: begin
          // pci_cfg registered its read data on the ISSUE edge; it is valid now.
          rsp_rdata <= cfg_iswrite ? 32'h0 : cfg_read_val;
          rsp_valid <= owner_oh;
          state     <= RESP;
        end

        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end

        default: begin
          cfg_enable <= 1'b0;
          rsp_valid  <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_cfg_arb.sv
// -----------------------------------------------------------------------------
// tb_pci_cfg_arb
//
// Self-checking bench for pci_cfg_arb (NREQ = 2, OFF_W = 6). A small pci_cfg
// stand-in answers accesses with one cycle of read latency. A monitor on the
// falling edge pushes the expected completion for every accepted request into a
// scoreboard queue and pops it when rsp_valid pulses; it also checks the ISSUE
// cycle fields. A table of single transactions plus hand-written sequences
// (exact timing, arbitration order, back-to-back spacing, reset abort, idle)
// drive the stimulus. Build with +define+PCI_CFG_ARB_RR_EN to check round-robin.
// -----------------------------------------------------------------------------
module tb_pci_cfg_arb;

  localparam int NREQ  = 2;
  localparam int OFF_W = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid   = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_iswrite = '0;
  logic [NREQ*OFF_W-1:0] req_offset  = '0;
  logic [NREQ*32-1:0]    req_wdata   = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  cfg_enable;
  logic                  cfg_iswrite;
  logic [OFF_W-1:0]      cfg_offset;
  logic [31:0]           cfg_write_val;
  logic [31:0]           cfg_read_val;

  always #5 clk = ~clk;

  pci_cfg_arb #(.NREQ(NREQ), .OFF_W(OFF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_iswrite  (req_iswrite),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .cfg_enable   (cfg_enable),
    .cfg_iswrite  (cfg_iswrite),
    .cfg_offset   (cfg_offset),
    .cfg_write_val(cfg_write_val),
    .cfg_read_val (cfg_read_val)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Power-on contents of the register file: a few fixed values, the rest a
  // recognisable pattern tied to the offset.
  function automatic logic [31:0] def_val(input logic [OFF_W-1:0] off);
    if (off == 6'h00) return 32'h1234_5678;
    if (off == 6'h05) return 32'hFFFF_FFFF;
    return 32'hA500_0000 | 32'(off);
  endfunction

  // pci_cfg stand-in: read data registered on the enable edge.
  logic [31:0] cfg_mem  [64];
  logic        cfg_wrtn [64] = '{default: 1'b0};
  always @(posedge clk) begin
    if (cfg_enable) begin
      if (cfg_iswrite) begin
        cfg_mem[cfg_offset]  <= cfg_write_val;
        cfg_wrtn[cfg_offset] <= 1'b1;
      end else begin
        cfg_read_val <= cfg_wrtn[cfg_offset] ? cfg_mem[cfg_offset] : def_val(cfg_offset);
      end
    end
  end

  // Scoreboard and monitor state.
  typedef struct {
    int          owner;
    logic [31:0] rdata;
  } exp_rsp_t;

  exp_rsp_t    sb_q[$];
  int          accepts[$];
  int          en_cycles[$];
  int          cycle = 0;
  logic [31:0] ref_mem  [64];
  logic        ref_wrtn [64] = '{default: 1'b0};
  bit          iss_pend = 1'b0;
  logic        iss_wr;
  logic [5:0]  iss_off;
  logic [31:0] iss_wd;
  logic        prev_en = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [NREQ-1:0] last_rsp = '0;

  always @(negedge clk) begin
    exp_rsp_t        e;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] oh;
    int              w;
    cycle++;
    if (!rst) begin
      sb_q.delete();
      iss_pend = 1'b0;
      prev_en  = 1'b0;
    end else begin
      if (iss_pend) begin
        check("issue_enable",  32'(cfg_enable),  1);
        check("issue_iswrite", 32'(cfg_iswrite), 32'(iss_wr));
        check("issue_offset",  32'(cfg_offset),  32'(iss_off));
        if (iss_wr) check("issue_wdata", cfg_write_val, iss_wd);
        iss_pend = 1'b0;
      end else if (cfg_enable) begin
        check("unexpected_enable", 32'(cfg_enable), 0);
      end
      if (cfg_enable) begin
        check("enable_single_cycle", 32'(prev_en), 0);
        en_cycles.push_back(cycle);
      end
      prev_en = cfg_enable;

      if (req_ready != '0) begin
        check("ready_onehot", 32'($countones(req_ready)), 1);
        check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
      end
      acc = req_valid & req_ready;
      if (acc != '0) begin
        w = acc[0] ? 0 : 1;
        accepts.push_back(w);
        iss_pend = 1'b1;
        iss_wr   = req_iswrite[w];
        iss_off  = req_offset[w*OFF_W +: OFF_W];
        iss_wd   = req_wdata[w*32 +: 32];
        e.owner  = w;
        if (iss_wr) begin
          e.rdata           = 32'h0;
          ref_mem[iss_off]  = iss_wd;
          ref_wrtn[iss_off] = 1'b1;
        end else begin
          e.rdata = ref_wrtn[iss_off] ? ref_mem[iss_off] : def_val(iss_off);
        end
        sb_q.push_back(e);
      end

      if (rsp_valid != '0) begin
        check("rsp_ready_overlap", 32'(rsp_valid & req_ready), 0);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e  = sb_q.pop_front();
          oh = '0;
          oh[e.owner] = 1'b1;
          check("rsp_owner", 32'(rsp_valid), 32'(oh));
          check("rsp_rdata", rsp_rdata, e.rdata);
          last_rdata = rsp_rdata;
          last_rsp   = rsp_valid;
        end
      end
    end
  end

  // One request from requester r; returns once it has been accepted.
  task automatic send(input int r, input logic wr, input logic [5:0] off, input logic [31:0] wd);
    logic got;
    @(posedge clk); #1;
    req_iswrite[r]               = wr;
    req_offset[r*OFF_W +: OFF_W] = off;
    req_wdata[r*32 +: 32]        = wd;
    req_valid[r]                 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = req_ready[r];
    end
    check("ready_timeout", 32'(got), 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Wait for all outstanding completions to arrive, bounded.
  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && !iss_pend;
    end
    check("drain_timeout", 32'(done), 1);
  endtask

  typedef struct {
    int          r;
    logic        wr;
    logic [5:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   base;
    int   exp_g[4];
    logic quiet;

    vecs[0] = '{0, 1'b0, 6'h00, 32'h0,         32'h1234_5678};
    vecs[1] = '{1, 1'b0, 6'h05, 32'h0,         32'hFFFF_FFFF};
    vecs[2] = '{0, 1'b1, 6'h04, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1, 1'b0, 6'h04, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{0, 1'b0, 6'h3F, 32'h0,         32'hA500_003F};
    vecs[5] = '{1, 1'b1, 6'h3F, 32'h0000_1234, 32'h0};
    vecs[6] = '{0, 1'b0, 6'h3F, 32'h0,         32'h0000_1234};
    vecs[7] = '{1, 1'b0, 6'h01, 32'h0,         32'hA500_0001};

    // Reset state, with requests pending that must not be acknowledged.
    req_valid = 2'b11;
    #2;
    check("reset_req_ready",  32'(req_ready),     0);
    check("reset_rsp_valid",  32'(rsp_valid),     0);
    check("reset_rsp_rdata",  rsp_rdata,          0);
    check("reset_cfg_enable", 32'(cfg_enable),    0);
    check("reset_cfg_iswr",   32'(cfg_iswrite),   0);
    check("reset_cfg_offset", 32'(cfg_offset),    0);
    check("reset_cfg_wval",   cfg_write_val,      0);
    req_valid = '0;
    #20 rst = 1'b1;

    // Exact timing of a read from req0 at offset 0.
    @(posedge clk); #1;
    req_iswrite[0] = 1'b0;
    req_offset[0 +: OFF_W] = 6'h00;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t0_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_cfg_enable",  32'(cfg_enable),  1);
    check("t1_cfg_iswrite", 32'(cfg_iswrite), 0);
    check("t1_cfg_offset",  32'(cfg_offset),  0);
    check("t1_req_ready",   32'(req_ready),   0);
    @(negedge clk);
    check("t2_cfg_enable",  32'(cfg_enable),  0);
    check("t2_rsp_valid",   32'(rsp_valid),   0);
    @(negedge clk);
    check("t3_rsp_valid",   32'(rsp_valid),   32'h1);
    check("t3_rsp_rdata",   rsp_rdata,        32'h1234_5678);
    @(negedge clk);
    check("t4_rsp_valid",   32'(rsp_valid),   0);

    // Table of single transactions.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].r, vecs[i].wr, vecs[i].off, vecs[i].wd);
      drain();
      check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_owner", i), 32'(last_rsp), 32'(1) << vecs[i].r);
    end

    // Both requesters held valid for four grants.
`ifdef PCI_CFG_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    base = accepts.size();
    @(posedge clk); #1;
    req_iswrite = 2'b00;
    req_offset  = {6'h05, 6'h00};
    req_valid   = 2'b11;
    for (int n = 0; n < 40 && accepts.size() < base + 4; n++) @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    drain();
    check("fair_count", 32'(accepts.size() >= base + 4), 1);
    if (accepts.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("fair_grant%0d", k), 32'(accepts[base+k]), 32'(exp_g[k]));
      end
    end

    // Back-to-back from req1: enable pulses exactly four cycles apart.
    base = en_cycles.size();
    @(posedge clk); #1;
    req_offset[OFF_W +: OFF_W] = 6'h05;
    req_valid[1] = 1'b1;
    for (int n = 0; n < 40 && en_cycles.size() < base + 3; n++) @(negedge clk);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain();
    check("b2b_count", 32'(en_cycles.size() >= base + 3), 1);
    if (en_cycles.size() >= base + 3) begin
      check("b2b_gap0", 32'(en_cycles[base+1] - en_cycles[base]),   4);
      check("b2b_gap1", 32'(en_cycles[base+2] - en_cycles[base+1]), 4);
    end

    // Reset asserted during WAIT aborts the access.
    @(posedge clk); #1;
    req_iswrite[0] = 1'b0;
    req_offset[0 +: OFF_W] = 6'h05;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 20 && !req_ready[0]; n++) @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;   // now in ISSUE
    @(posedge clk); #2;                        // now in WAIT
    rst = 1'b0;
    req_valid[1] = 1'b1;
    #1;
    check("abort_req_ready",  32'(req_ready),   0);
    check("abort_rsp_valid",  32'(rsp_valid),   0);
    check("abort_rsp_rdata",  rsp_rdata,        0);
    check("abort_cfg_enable", 32'(cfg_enable),  0);
    check("abort_cfg_offset", 32'(cfg_offset),  0);
    check("abort_cfg_wval",   cfg_write_val,    0);
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #2 rst = 1'b1;
    quiet = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      quiet = quiet | cfg_enable | (|rsp_valid) | (|req_ready);
    end
    check("abort_no_stale", 32'(quiet), 0);
    send(0, 1'b0, 6'h00, 32'h0);
    drain();
    check("post_reset_rdata", last_rdata, 32'h1234_5678);
    check("post_reset_owner", 32'(last_rsp), 32'h1);

    // Idle for 20 cycles.
    quiet = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      quiet = quiet | cfg_enable | (|rsp_valid) | (|req_ready);
    end
    check("idle_quiet", 32'(quiet), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
